e_alu_iq: RTL

Four-entry, in-order-compacting issue queue feeding the execute-stage integer ALU. It accepts renamed ALU micro-ops from dispatch and captures source operands from two writeback wakeup ports. It selects the oldest micro-op whose operands are both ready and presents it, fully resolved, to the ALU. Results are not handled here; the ALU output is consumed by the writeback stage.

---
 rtl/e_alu_iq_if.sv | 62 ++++++
 rtl/e_alu_iq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/e_alu_iq_if.sv
// Bundles the dispatch, wakeup and issue signals of the ALU issue queue.
// The slave view belongs to the queue; the master view belongs to the
// surrounding pipeline (dispatch, writeback and the ALU stage).
interface e_alu_iq_if #(
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6
);
  logic              flush_i;

  logic              dis_valid_i;
  logic              dis_ready_o;
  logic [PREG_W-1:0] dis_r0_tag_i;
  logic [PREG_W-1:0] dis_r1_tag_i;
  logic              dis_r0_rdy_i;
  logic              dis_r1_rdy_i;
  logic [31:0]       dis_r0_i;
  logic [31:0]       dis_r1_i;
  logic [31:0]       dis_pc_i;
  logic [2:0]        dis_grand_op_i;
  logic [2:0]        dis_op_i;
  logic [ROB_W-1:0]  dis_rob_i;
  logic [PREG_W-1:0] dis_wreg_i;

  logic              wk0_valid_i;
  logic              wk1_valid_i;
  logic [PREG_W-1:0] wk0_tag_i;
  logic [PREG_W-1:0] wk1_tag_i;
  logic [31:0]       wk0_data_i;
  logic [31:0]       wk1_data_i;

  logic              iss_valid_o;
  logic              iss_ready_i;
  logic [31:0]       iss_r0_o;
  logic [31:0]       iss_r1_o;
  logic [31:0]       iss_pc_o;
  logic [2:0]        iss_grand_op_o;
  logic [2:0]        iss_op_o;
  logic [ROB_W-1:0]  iss_rob_o;
  logic [PREG_W-1:0] iss_wreg_o;

  modport slave (
    input  flush_i,
    input  dis_valid_i, dis_r0_tag_i, dis_r1_tag_i, dis_r0_rdy_i, dis_r1_rdy_i,
    input  dis_r0_i, dis_r1_i, dis_pc_i, dis_grand_op_i, dis_op_i, dis_rob_i, dis_wreg_i,
    output dis_ready_o,
    input  wk0_valid_i, wk1_valid_i, wk0_tag_i, wk1_tag_i, wk0_data_i, wk1_data_i,
    input  iss_ready_i,
    output iss_valid_o, iss_r0_o, iss_r1_o, iss_pc_o, iss_grand_op_o, iss_op_o,
    output iss_rob_o, iss_wreg_o
  );

  modport master (
    output flush_i,
    output dis_valid_i, dis_r0_tag_i, dis_r1_tag_i, dis_r0_rdy_i, dis_r1_rdy_i,
    output dis_r0_i, dis_r1_i, dis_pc_i, dis_grand_op_i, dis_op_i, dis_rob_i, dis_wreg_i,
    input  dis_ready_o,
    output wk0_valid_i, wk1_valid_i, wk0_tag_i, wk1_tag_i, wk0_data_i, wk1_data_i,
    output iss_ready_i,
    input  iss_valid_o, iss_r0_o, iss_r1_o, iss_pc_o, iss_grand_op_o, iss_op_o,
    input  iss_rob_o, iss_wreg_o
  );
endinterface

// File: rtl/e_alu_iq.sv
// Four-entry compacting issue queue in front of the integer ALU.
// Slot 0 holds the oldest micro-op; valid entries stay packed from slot 0.
// Operands are captured from two wakeup ports and the oldest fully ready
// entry is moved into a single issue register feeding the ALU.
module e_alu_iq #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  e_alu_iq_if.slave     bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]       r0;
    logic [31:0]       r1;
    logic [31:0]       pc;
    logic [2:0]        grand_op;
    logic [2:0]        op;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] wreg;
  } payload_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] t0;
    logic              rdy0;
    logic [PREG_W-1:0] t1;
    logic              rdy1;
    payload_t          p;
  } entry_t;

  entry_t            q     [DEPTH];
  entry_t            q_nxt [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  payload_t          sel_p;
  logic              xfer;
  logic              accept;
  logic              dis_ready;
  int unsigned       slot;
  entry_t            dis_e;
  logic              iss_valid;
  payload_t          iss_p;

  logic              wk0_v, wk1_v;
  logic [PREG_W-1:0] wk0_t, wk1_t;
  logic [31:0]       wk0_d, wk1_d;

  assign wk0_v = bus.wk0_valid_i;
  assign wk1_v = bus.wk1_valid_i;
  assign wk0_t = bus.wk0_tag_i;
  assign wk1_t = bus.wk1_tag_i;
  assign wk0_d = bus.wk0_data_i;
  assign wk1_d = bus.wk1_data_i;

  // Capture a waiting source from the wakeup ports; port 0 has priority.
  function automatic logic [32:0] wake_src(input logic rdy, input logic [PREG_W-1:0] tag,
                                           input logic [31:0] data);
    logic [32:0] r;
    r = {rdy, data};
    if (!rdy) begin
      if (wk0_v && (tag == wk0_t))      r = {1'b1, wk0_d};
      else if (wk1_v && (tag == wk1_t)) r = {1'b1, wk1_d};
    end
    return r;
  endfunction

  assign dis_ready = (count < CNT_W'(DEPTH));
  assign accept    = bus.dis_valid_i && dis_ready && !bus.flush_i;
  assign xfer      = sel_found && (!iss_valid || bus.iss_ready_i) && !bus.flush_i;
  assign slot      = 32'(count) - 32'(xfer);

  // Oldest entry whose registered source ready bits are both set.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_p     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && q[i].valid && q[i].rdy0 && q[i].rdy1) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_p     = q[i].p;
      end
    end
  end

  // Incoming micro-op, with sources bypassed from same-cycle wakeups.
  always_comb begin
    dis_e            = '0;
    dis_e.valid      = 1'b1;
    dis_e.t0         = bus.dis_r0_tag_i;
    dis_e.t1         = bus.dis_r1_tag_i;
    dis_e.p.pc       = bus.dis_pc_i;
    dis_e.p.grand_op = bus.dis_grand_op_i;
    dis_e.p.op       = bus.dis_op_i;
    dis_e.p.rob      = bus.dis_rob_i;
    dis_e.p.wreg     = bus.dis_wreg_i;
    {dis_e.rdy0, dis_e.p.r0} = wake_src(bus.dis_r0_rdy_i, bus.dis_r0_tag_i, bus.dis_r0_i);
    {dis_e.rdy1, dis_e.p.r1} = wake_src(bus.dis_r1_rdy_i, bus.dis_r1_tag_i, bus.dis_r1_i);
  end

  // Next queue contents: wake, remove-and-compact, then append at the tail.
  // Ascending copy of slot i+1 into i reads slot i+1 before it is overwritten.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_nxt[i] = q[i];
      if (q[i].valid) begin
        {q_nxt[i].rdy0, q_nxt[i].p.r0} = wake_src(q[i].rdy0, q[i].t0, q[i].p.r0);
        {q_nxt[i].rdy1, q_nxt[i].p.r1} = wake_src(q[i].rdy1, q[i].t1, q[i].p.r1);
      end
    end
    if (xfer) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (i >= 32'(sel_idx)) q_nxt[i] = q_nxt[i+1];
      end
      q_nxt[DEPTH-1] = '0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (accept && (i == slot)) q_nxt[i] = dis_e;
    end
    count_nxt = count + CNT_W'(accept) - CNT_W'(xfer);
  end

  // Queue state; flush empties it and drops any same-cycle dispatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else if (bus.flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      q     <= q_nxt;
      count <= count_nxt;
    end
  end

  // Issue register; holds its contents while the ALU stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_p     <= '0;
    end else if (bus.flush_i) begin
      iss_valid <= 1'b0;
    end else if (xfer) begin
      iss_valid <= 1'b1;
      iss_p     <= sel_p;
    end else if (bus.iss_ready_i) begin
      iss_valid <= 1'b0;
    end
  end

  assign bus.dis_ready_o    = dis_ready;
  assign bus.iss_valid_o    = iss_valid;
  assign bus.iss_r0_o       = iss_p.r0;
  assign bus.iss_r1_o       = iss_p.r1;
  assign bus.iss_pc_o       = iss_p.pc;
  assign bus.iss_grand_op_o = iss_p.grand_op;
  assign bus.iss_op_o       = iss_p.op;
  assign bus.iss_rob_o      = iss_p.rob;
  assign bus.iss_wreg_o     = iss_p.wreg;
endmodule
